// File: rtl/pwm_dac_output.sv
// pwm_dac_output: sample FIFO feeding a PWM generator whose output drives a
// GPIO pad and becomes a DAC after external RC filtering.
//
// Each sample sets the duty for exactly one PWM period of 2^SAMPLE_W ticks.
// A tick occurs every prescale_i+1 clocks. If the FIFO is empty at a period
// boundary, the previous duty is repeated and the sticky underrun_o flag is set.
//
// Optional build macro: PWM_DAC_COMPLEMENT_EN adds the complementary output
// pwm_n_o. With the macro undefined, the port and its logic are absent.
//
// s_valid_i / s_ready_o handshake: a sample transfers on every clock edge
// where both s_valid_i and s_ready_o are high. s_ready_o depends only on the
// registered occupancy. The source may hold s_valid_i high while waiting.
//
// state_o is a debug view of the FSM: 0 = IDLE, 1 = RUN.
module pwm_dac_output #(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic [7:0]                    prescale_i,
  input  logic                          s_valid_i,
  input  logic [SAMPLE_W-1:0]           s_data_i,
  output logic                          s_ready_o,
  output logic                          pwm_o,
  output logic                          pwm_oeb_o,
  output logic                          underrun_o,
  input  logic                          underrun_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
`ifdef PWM_DAC_COMPLEMENT_EN
  output logic                          pwm_n_o,
`endif
  output logic                          state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [LW-1:0]       LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          pre_q, pre_d;
  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                oeb_q, oeb_d;
  logic                und_q, und_d;
  logic [LW-1:0]       level_q, level_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];

  logic tick;
  logic load;
  logic push;
  logic pop;
  logic duty_hit;

  assign s_ready_o  = (level_q != LVL_FULL);
  assign push       = s_valid_i & s_ready_o;
  assign duty_hit   = (cnt_q < duty_q);

  assign pwm_o      = pwm_q;
  assign pwm_oeb_o  = oeb_q;
  assign underrun_o = und_q;
  assign level_o    = level_q;
  assign state_o    = (state_q == RUN);

  // Next-state logic: FSM, prescaler, phase counter, duty load, FIFO pointers.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    pwm_d   = 1'b0;
    oeb_d   = 1'b1;
    und_d   = und_q;
    level_d = level_q;
    head_d  = head_q;
    tail_d  = tail_q;
    tick    = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pre_d = '0;
        if (enable_i) begin
          // Start: the first sample is loaded so the first period uses it.
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else begin
          // >= lets a reduced prescale_i take effect without a long wrap.
          if (pre_q >= prescale_i) begin
            pre_d = '0;
            tick  = 1'b1;
          end else begin
            pre_d = pre_q + 8'd1;
          end
          if (tick) begin
            cnt_d = cnt_q + SAMPLE_W'(1);
            if (cnt_q == CNT_MAX) begin
              load = 1'b1;
            end
          end
          pwm_d = duty_hit;
          oeb_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Duty load pops the head; an empty FIFO repeats the old duty and flags it.
    if (load) begin
      if (level_q != '0) begin
        pop    = 1'b1;
        duty_d = mem[head_q];
      end
    end

    // A new underrun wins over a coincident clear.
    if (load && (level_q == '0)) begin
      und_d = 1'b1;
    end else if (underrun_clr_i) begin
      und_d = 1'b0;
    end

    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      oeb_q   <= 1'b1;
      und_q   <= 1'b0;
      level_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      oeb_q   <= oeb_d;
      und_q   <= und_d;
      level_q <= level_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[tail_q] <= s_data_i;
    end
  end

`ifdef PWM_DAC_COMPLEMENT_EN
  logic pwmn_q;
  logic pwmn_d;

  // Complement is low outside RUN, so it never overlaps pwm_o.
  always_comb begin
    pwmn_d = 1'b0;
    if ((state_q == RUN) && enable_i) begin
      pwmn_d = ~duty_hit;
    end
  end

  // Complementary output register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pwmn_q <= 1'b0;
    end else begin
      pwmn_q <= pwmn_d;
    end
  end

  assign pwm_n_o = pwmn_q;
`endif

endmodule

// File: tb/tb_pwm_dac_output.sv
// Testbench for pwm_dac_output (SAMPLE_W=8, FIFO_DEPTH=4).
// The reference model tracks elapsed RUN clocks and derives the phase
// arithmetically: cnt = (elapsed mod period) / (prescale+1).
module tb_pwm_dac_output;
  localparam int SW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    prescale = 8'd0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          clr = 1'b0;
  logic          s_ready;
  logic          pwm;
  logic          pwm_oeb;
  logic          underrun;
  logic [2:0]    level;
  logic          state;
`ifdef PWM_DAC_COMPLEMENT_EN
  logic          pwm_n;
`endif

  pwm_dac_output #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .enable_i       (enable),
    .prescale_i     (prescale),
    .s_valid_i      (s_valid),
    .s_data_i       (s_data),
    .s_ready_o      (s_ready),
    .pwm_o          (pwm),
    .pwm_oeb_o      (pwm_oeb),
    .underrun_o     (underrun),
    .underrun_clr_i (clr),
    .level_o        (level),
`ifdef PWM_DAC_COMPLEMENT_EN
    .pwm_n_o        (pwm_n),
`endif
    .state_o        (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [SW-1:0] exp_q[$];
  bit m_run;
  int m_e;
  int m_duty;
  bit m_pwm;
  bit m_oeb;
  bit m_pwmn;
  bit m_und;

  typedef struct {
    logic          valid;
    logic [SW-1:0] data;
    logic          en;
    logic          uclr;
    logic [2:0]    lvl;
    logic          rdy;
    logic          p;
    logic          oeb;
    logic          und;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run  = 1'b0;
    m_e    = 0;
    m_duty = 0;
    m_pwm  = 1'b0;
    m_oeb  = 1'b1;
    m_pwmn = 1'b0;
    m_und  = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs held at that edge.
  task automatic model_edge();
    int p_len;
    int phase;
    int c;
    bit load;
    bit push_ok;
    bit und_set;
    p_len   = int'(prescale) + 1;
    load    = 1'b0;
    und_set = 1'b0;
    push_ok = s_valid && (exp_q.size() < DEPTH);
    if (!m_run) begin
      m_pwm  = 1'b0;
      m_oeb  = 1'b1;
      m_pwmn = 1'b0;
      if (enable) begin
        m_run = 1'b1;
        m_e   = 0;
        load  = 1'b1;
      end
    end else if (!enable) begin
      m_run  = 1'b0;
      m_pwm  = 1'b0;
      m_oeb  = 1'b1;
      m_pwmn = 1'b0;
    end else begin
      phase  = m_e % (p_len * 256);
      c      = phase / p_len;
      m_pwm  = (c < m_duty);
      m_pwmn = !m_pwm;
      m_oeb  = 1'b0;
      if (phase == p_len * 256 - 1) load = 1'b1;
      m_e++;
    end
    if (load) begin
      if (exp_q.size() > 0) m_duty = int'(exp_q.pop_front());
      else und_set = 1'b1;
    end
    if (und_set) m_und = 1'b1;
    else if (clr) m_und = 1'b0;
    if (push_ok) exp_q.push_back(s_data);
  endtask

  // Driver: advance one clock, update the model, compare every output.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("pwm", pwm, m_pwm);
    chk("pwm_oeb", pwm_oeb, m_oeb);
    chk("underrun", underrun, m_und);
    chk("level", level, exp_q.size());
    chk("s_ready", s_ready, exp_q.size() != DEPTH);
    chk("state", state, m_run);
`ifdef PWM_DAC_COMPLEMENT_EN
    chk("pwm_n", pwm_n, m_pwmn);
    if (pwm_n && pwm) chk("pwm_overlap", 1, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    s_valid = 1'b0;
    clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [SW-1:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    int hi;
    int exp_hi[4];
    logic [SW-1:0] b2b[4];

    model_reset();
    step();
    step();
    // Reset values
    chk("rst_pwm", pwm, 0);
    chk("rst_oeb", pwm_oeb, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 1);
    rst = 1'b0;

    // Table: fill FIFO while idle, backpressure, start, accept 5th sample.
    tbl[0]  = '{1'b1, 8'd10, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'd20, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd99, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'd30, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'd40, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'd50, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'd50, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'd60, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0,  1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    prescale = 8'd0;
    for (int i = 0; i < 11; i++) begin
      s_valid = tbl[i].valid;
      s_data  = tbl[i].data;
      enable  = tbl[i].en;
      clr     = tbl[i].uclr;
      step();
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_ready", s_ready, tbl[i].rdy);
      chk("tbl_pwm", pwm, tbl[i].p);
      chk("tbl_oeb", pwm_oeb, tbl[i].oeb);
      chk("tbl_underrun", underrun, tbl[i].und);
    end
    s_valid = 1'b0;
    clr = 1'b0;

    // Basic waveform and underrun clear.
    do_reset();
    prescale = 8'd0;
    push_one(8'd64);
    enable = 1'b1;
    step();
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      step();
      hi += int'(pwm);
      if (j == 254) chk("basic_und_before", underrun, 0);
    end
    chk("basic_hi_p1", hi, 64);
    chk("basic_und_boundary", underrun, 1);
    hi = 0;
    for (int j = 0; j < 255; j++) begin
      step();
      hi += int'(pwm);
    end
    clr = 1'b1;
    step();
    hi += int'(pwm);
    clr = 1'b0;
    chk("basic_hi_p2", hi, 64);
    chk("uclr_at_boundary", underrun, 1);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("uclr_plain", underrun, 0);
    enable = 1'b0;
    step();
    chk("idle_pwm", pwm, 0);
    chk("idle_oeb", pwm_oeb, 1);

    // Back-to-back samples at prescale 3.
    do_reset();
    prescale = 8'd3;
    b2b[0] = 8'd10;  b2b[1] = 8'd200; b2b[2] = 8'd0;  b2b[3] = 8'd255;
    exp_hi[0] = 40;  exp_hi[1] = 800; exp_hi[2] = 0;  exp_hi[3] = 1020;
    for (int i = 0; i < 4; i++) push_one(b2b[i]);
    chk("b2b_level", level, 4);
    enable = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      hi = 0;
      for (int j = 0; j < 1024; j++) begin
        step();
        hi += int'(pwm);
        if (k == 3 && j == 1022) chk("b2b_no_underrun", underrun, 0);
      end
      chk("b2b_hi", hi, exp_hi[k]);
    end
    enable = 1'b0;
    step();

    // Reset mid-period with two samples queued.
    do_reset();
    prescale = 8'd0;
    push_one(8'd200);
    push_one(8'd50);
    push_one(8'd30);
    enable = 1'b1;
    step();
    repeat (100) step();
    chk("mid_pwm_before", pwm, 1);
    chk("mid_level_before", level, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pwm", pwm, 0);
    chk("mid_rst_oeb", pwm_oeb, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", s_ready, 1);
    enable = 1'b0;
    step();
    rst = 1'b0;

    // Randomized run against the model.
    prescale = 8'($urandom_range(0, 2));
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      s_valid = ($urandom_range(0, 199) == 0);
      s_data  = 8'($urandom);
      clr     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) enable = ~enable;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
